// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared FSM state type and default datapath widths for the CNN accumulator
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        REQUANT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 8;

endpackage

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - combinational shift and saturate/truncate of the window sum
// Saturation is enabled by defining OUT_SAT_EN; otherwise the shifted sum is truncated.
module conv_requant #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] out_data
);

    logic [ACC_W-1:0] shifted;

    assign shifted = acc >> SHIFT;

`ifdef OUT_SAT_EN
    localparam logic [ACC_W-1:0] MAX_VAL = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    assign out_data = (shifted > MAX_VAL) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`else
    logic unused_high;

    assign unused_high = &{1'b0, shifted[ACC_W-1:OUT_W]};
    assign out_data    = shifted[OUT_W-1:0];
`endif

endmodule

// File: rtl/conv_accum.sv
// rtl/conv_accum.sv - bias-preloaded accumulation of one convolution window, requantized to an activation
// OUT_SAT_EN selects saturating requantization (consumed only by conv_requant).
module conv_accum
    import cnn_pkg::*;
#(
    parameter int N_TERMS = 9,
    parameter int PROD_W  = cnn_pkg::PROD_W,
    parameter int ACC_W   = cnn_pkg::ACC_W,
    parameter int OUT_W   = cnn_pkg::OUT_W,
    parameter int SHIFT   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  requant_data;
    logic              accept;

    assign prod_ready = (state == ACCUM);
    assign busy       = (state != IDLE);
    assign accept     = prod_valid && prod_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (accept && cnt == LAST_CNT) state_next = REQUANT;
            REQUANT: state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= bias;
                        cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + {{(ACC_W-PROD_W){1'b0}}, prod};
                        cnt <= cnt + 1'b1;
                    end
                end
                REQUANT: begin
                    out_data  <= requant_data;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    conv_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc      (acc),
        .out_data (requant_data)
    );

endmodule

// File: tb/tb_conv_accum.sv
// tb/tb_conv_accum.sv - directed and randomized windows against an arithmetic reference model
module tb_conv_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_b;
    logic [23:0] bias, bias_b;
    logic        prod_valid, prod_valid_b;
    logic [15:0] prod, prod_b;
    logic        prod_ready, prod_ready_b;
    logic        out_valid, out_valid_b;
    logic        out_ready, out_ready_b;
    logic [7:0]  out_data, out_data_b;
    logic        busy, busy_b;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] prods [9];

    always #5 clk = ~clk;

    conv_accum #(.N_TERMS(9), .SHIFT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    conv_accum #(.N_TERMS(1), .SHIFT(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bias(bias_b),
        .prod_valid(prod_valid_b), .prod(prod_b), .prod_ready(prod_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
    );

    function automatic logic [7:0] model(input logic [23:0] b, input longint unsigned s);
        longint unsigned a, sh;
        a  = (longint'(b) + s) % (64'd1 << 24);
        sh = a >> 8;
`ifdef OUT_SAT_EN
        return (sh > 255) ? 8'hFF : sh[7:0];
`else
        return sh[7:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input string tag, input logic [23:0] b, input bit gaps,
                              input int hold, input bit misuse);
        longint unsigned sum = 0;
        logic [7:0]      exp;
        for (int i = 0; i < 9; i++) sum += prods[i];
        exp = model(b, sum);
        start = 1'b1; bias = b; out_ready = 1'b0;
        step();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ready"}, 32'(prod_ready), 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    prod_valid = 1'b0;
                    if (misuse) begin start = 1'b1; bias = 24'($urandom); end
                    step();
                    start = 1'b0;
                end
            end
            prod_valid = 1'b1; prod = prods[i];
            if (misuse) begin start = 1'b1; bias = 24'($urandom); end
            if (i == 8) out_ready = (hold == 0);
            step();
            start = 1'b0;
        end
        prod_valid = 1'b0;
        check({tag, "_valid_requant"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        for (int k = 0; k < hold; k++) begin
            prod_valid = 1'b1; prod = 16'($urandom);
            start = misuse; bias = 24'($urandom);
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp));
            check({tag, "_hold_pready"}, 32'(prod_ready), 32'd0);
        end
        prod_valid = 1'b0;
        out_ready = 1'b1;
        start = misuse;
        step();
        start = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; bias = '0; prod_valid = 1'b0; prod = '0; out_ready = 1'b0;
        start_b = 1'b0; bias_b = '0; prod_valid_b = 1'b0; prod_b = '0; out_ready_b = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pready", 32'(prod_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        reset = 1'b1;
        step();

        // T2 basic
        for (int i = 0; i < 9; i++) prods[i] = 16'h0100;
        run_window("t2", 24'h0, 1'b0, 0, 1'b0);
        check("t2_model", 32'(model(24'h0, 64'h900)), 32'd9);

        // T1 reset mid-window after 4 products
        start = 1'b1; bias = 24'h123456;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1; prod = 16'($urandom);
            step();
        end
        prod_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_pready", 32'(prod_ready), 32'd0);
        check("t1_valid", 32'(out_valid), 32'd0);
        check("t1_data", 32'(out_data), 32'd0);
        #1 reset = 1'b1;
        step();
        check("t1_idle", 32'(busy), 32'd0);

        // T3 bias with random gaps
        for (int i = 0; i < 9; i++) prods[i] = 16'((i + 1) * 256);
        run_window("t3", 24'h000180, 1'b1, 0, 1'b0);
        check("t3_model", 32'(model(24'h000180, 64'h2D00)), 32'h2E);

        // T4 saturation / truncation
        for (int i = 0; i < 9; i++) prods[i] = 16'h8000;
        run_window("t4", 24'h0, 1'b0, 0, 1'b0);

        // T6 misuse: products offered in IDLE are not accepted
        prod_valid = 1'b1; prod = 16'hFFFF;
        step();
        check("t6_idle_pready", 32'(prod_ready), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        step();
        prod_valid = 1'b0;

        // T5 backpressure with start/prod pulses in HOLD and start during ACCUM
        for (int i = 0; i < 9; i++) prods[i] = 16'($urandom);
        run_window("t5", 24'($urandom), 1'b1, 5, 1'b1);
        for (int i = 0; i < 9; i++) prods[i] = 16'($urandom);
        run_window("t5_next", 24'($urandom), 1'b0, 0, 1'b0);

        // Randomized windows
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 9; i++) prods[i] = 16'($urandom);
            run_window("rnd", 24'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // T6 wrap with N_TERMS=1
        start_b = 1'b1; bias_b = 24'hFFFFFF;
        step();
        start_b = 1'b0;
        check("t6b_pready", 32'(prod_ready_b), 32'd1);
        prod_valid_b = 1'b1; prod_b = 16'h0001; out_ready_b = 1'b1;
        step();
        prod_valid_b = 1'b0;
        check("t6b_valid_requant", 32'(out_valid_b), 32'd0);
        check("t6b_pready_after", 32'(prod_ready_b), 32'd0);
        step();
        check("t6b_valid", 32'(out_valid_b), 32'd1);
        check("t6b_data", 32'(out_data_b), 32'(model(24'hFFFFFF, 64'd1)));
        step();
        check("t6b_valid_drop", 32'(out_valid_b), 32'd0);
        check("t6b_idle", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
